tas_pkt_tx: RTL and testbench

TAS_PKT_TX -- requirements
Module: tas_pkt_tx

---
 rtl/tas_pkt_tx.sv | 188 ++++++++++++++++++
 tb/tb_tas_pkt_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tas_pkt_tx.sv
// Packet serialiser: buffers payload bytes in a small FIFO and, once four are
// available, transmits a 5-byte packet (header + 4 payload bytes) LSB first.
// Each byte occupies 8 cycles with data_ena high, and there are GAP_CYCLES
// GAP cycles plus one LOAD cycle between consecutive bytes.
module tas_pkt_tx #(
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       hdr_sel,
    output logic       serial_data,
    output logic       data_ena,
    output logic       busy,
    output logic       pkt_done
);

    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [7:0] HDR_A5   = 8'hA5;
    localparam logic [7:0] HDR_C3   = 8'hC3;
    localparam logic [2:0] PKT_LAST = 3'd5;   // bytes per packet

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push;
    logic             pop;

    // Transmit datapath
    logic [7:0] shreg;
    logic [7:0] load_byte;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [3:0] gap_cnt;
    logic       hdr_q;
    logic       start;

    assign in_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    // Byte 0 of a packet is the header; bytes 1-4 are popped from the FIFO.
    assign pop      = (state_q == LOAD) && (byte_cnt != 3'd0);
    assign start    = (state_q == IDLE) && (state_d == LOAD);
    assign load_byte = (byte_cnt == 3'd0) ? (hdr_q ? HDR_C3 : HDR_A5)
                                          : mem[rd_ptr];

    // FIFO storage write
    // NOTE: the storage array carries no reset; the pointers and count define
    // what is valid, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk_50) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fifo_cnt >= CNT_W'(4)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == 3'd7) begin
                    state_d = (byte_cnt < PKT_LAST) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transmit datapath and registered outputs; each output is computed for
    // the state being entered so it is valid in the same cycle as that state.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            hdr_q       <= 1'b0;
            serial_data <= 1'b0;
            data_ena    <= 1'b0;
            busy        <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            busy     <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Header choice is frozen here for the whole packet.
                        hdr_q    <= hdr_sel;
                        byte_cnt <= 3'd0;
                    end
                end
                LOAD: begin
                    shreg       <= load_byte;
                    serial_data <= load_byte[0];
                    data_ena    <= 1'b1;
                    bit_cnt     <= 3'd0;
                    byte_cnt    <= byte_cnt + 3'd1;
                end
                SHIFT: begin
                    if (bit_cnt == 3'd7) begin
                        serial_data <= 1'b0;
                        data_ena    <= 1'b0;
                        gap_cnt     <= 4'd0;
                        if (byte_cnt >= PKT_LAST) begin
                            pkt_done <= 1'b1;
                        end
                    end else begin
                        serial_data <= shreg[1];
                        shreg       <= {1'b0, shreg[7:1]};
                        bit_cnt     <= bit_cnt + 3'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                    data_ena <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tas_pkt_tx.sv
// Bench for tas_pkt_tx: two instances (GAP_CYCLES 2 and 5) share the same
// stimulus. Expected bytes are queued per instance when a packet is pushed and
// compared as the serial stream is deserialised; timing of runs, gaps, packet
// length, start latency and reset behaviour are checked alongside.
module tb_tas_pkt_tx;

    localparam int G0 = 2;
    localparam int G1 = 5;

    logic       clk_50;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       hdr_sel;
    logic       rdy  [2];
    logic       sd   [2];
    logic       de   [2];
    logic       bsy  [2];
    logic       done [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q [2][$];

    // Monitor state per instance
    int         cyc = 0;
    int         bit_idx      [2];
    int         bytes_in_pkt [2];
    int         hi_run       [2];
    int         lo_run       [2];
    int         first_cyc    [2];
    int         done_cnt     [2];
    int         de_total     [2];
    int         sd_viol      [2];
    logic       prev_de      [2];
    logic [7:0] shreg        [2];

    tas_pkt_tx #(.GAP_CYCLES(G0), .FIFO_DEPTH(8)) u_dut_g2 (
        .clk_50(clk_50), .reset_n(reset_n), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[0]), .hdr_sel(hdr_sel),
        .serial_data(sd[0]), .data_ena(de[0]), .busy(bsy[0]),
        .pkt_done(done[0])
    );

    tas_pkt_tx #(.GAP_CYCLES(G1), .FIFO_DEPTH(8)) u_dut_g5 (
        .clk_50(clk_50), .reset_n(reset_n), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[1]), .hdr_sel(hdr_sel),
        .serial_data(sd[1]), .data_ena(de[1]), .busy(bsy[1]),
        .pkt_done(done[1])
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Deserialise and time-check both serial streams on the falling edge.
    always @(negedge clk_50) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                bit_idx[i]      = 0;
                bytes_in_pkt[i] = 0;
                hi_run[i]       = 0;
                lo_run[i]       = 0;
                prev_de[i]      = 1'b0;
            end else begin
                if (!de[i] && sd[i]) sd_viol[i]++;
                if (de[i]) begin
                    de_total[i]++;
                    if (!prev_de[i]) begin
                        if (bytes_in_pkt[i] != 0)
                            check($sformatf("gap_low_d%0d", i), lo_run[i], gap_of(i) + 1);
                        else
                            first_cyc[i] = cyc;
                        hi_run[i] = 0;
                    end
                    hi_run[i]++;
                    shreg[i][bit_idx[i]] = sd[i];
                    bit_idx[i]++;
                    if (bit_idx[i] == 8) begin
                        bit_idx[i] = 0;
                        if (exp_q[i].size() == 0)
                            check($sformatf("unexpected_byte_d%0d", i), int'(shreg[i]), 256);
                        else
                            check($sformatf("byte%0d_d%0d", bytes_in_pkt[i], i),
                                  int'(shreg[i]), int'(exp_q[i].pop_front()));
                        bytes_in_pkt[i]++;
                    end
                end else begin
                    if (prev_de[i]) begin
                        check($sformatf("hi_run_d%0d", i), hi_run[i], 8);
                        lo_run[i] = 0;
                    end
                    lo_run[i]++;
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    check($sformatf("pkt_bytes_d%0d", i), bytes_in_pkt[i], 5);
                    check($sformatf("pkt_dur_d%0d", i), cyc - first_cyc[i] + 1,
                          5 * 8 + 4 * (gap_of(i) + 1) + 1);
                    bytes_in_pkt[i] = 0;
                end
                prev_de[i] = de[i];
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk_50);
        while (!(rdy[0] && rdy[1]) && k < 500) begin
            @(negedge clk_50);
            k++;
        end
        if (k >= 500) check("push_timeout", 0, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk_50);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic queue_pkt(input logic hsel, input logic [31:0] w);
        for (int i = 0; i < 2; i++) begin
            exp_q[i].push_back(hsel ? 8'hC3 : 8'hA5);
            for (int j = 0; j < 4; j++) exp_q[i].push_back(w[8*j +: 8]);
        end
    endtask

    // Header bit must appear two edges after the edge that made count 4.
    task automatic check_latency(input string tag);
        @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_lat1_de_d%0d", tag, i), int'(de[i]), 0);
            check($sformatf("%s_lat1_busy_d%0d", tag, i), int'(bsy[i]), 1);
        end
        @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_lat2_de_d%0d", tag, i), int'(de[i]), 1);
    endtask

    task automatic send_pkt(input string tag, input logic hsel, input logic [31:0] w);
        queue_pkt(hsel, w);
        hdr_sel = hsel;
        for (int j = 0; j < 4; j++) push_byte(w[8*j +: 8]);
        check_latency(tag);
    endtask

    task automatic wait_done(input int i, input int target);
        for (int k = 0; k < 3000 && done_cnt[i] < target; k++) @(negedge clk_50);
        check($sformatf("done_cnt_d%0d", i), done_cnt[i], target);
    endtask

    // A queued packet must start straight from the first IDLE cycle.
    task automatic check_b2b(input int i);
        int k;
        k = 0;
        do begin
            @(posedge clk_50);
            #1;
            k++;
        end while (!done[i] && k < 3000);
        check($sformatf("b2b_done_seen_d%0d", i), int'(done[i]), 1);
        @(posedge clk_50);
        #1;
        check($sformatf("b2b_load_de_d%0d", i), int'(de[i]), 0);
        @(posedge clk_50);
        #1;
        check($sformatf("b2b_shift_de_d%0d", i), int'(de[i]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill [16];
        int n;
        int de_snap [2];
        int done_snap [2];
        int k;

        for (int i = 0; i < 2; i++) begin
            bit_idx[i] = 0; bytes_in_pkt[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
            first_cyc[i] = 0; done_cnt[i] = 0; de_total[i] = 0; sd_viol[i] = 0;
            prev_de[i] = 1'b0; shreg[i] = 8'h00;
        end
        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        hdr_sel  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_de_d%0d", i), int'(de[i]), 0);
            check($sformatf("rst_sd_d%0d", i), int'(sd[i]), 0);
            check($sformatf("rst_busy_d%0d", i), int'(bsy[i]), 0);
            check($sformatf("rst_done_d%0d", i), int'(done[i]), 0);
            check($sformatf("rst_ready_d%0d", i), int'(rdy[i]), 1);
        end
        #44;
        reset_n = 1'b1;
        repeat (3) @(posedge clk_50);

        // Basic packet, header A5
        send_pkt("basic", 1'b0, 32'h44332211);
        wait_done(0, 1);
        wait_done(1, 1);

        // Header C3 chosen at start; toggling mid-packet must not matter
        send_pkt("hdr", 1'b1, 32'h88776655);
        repeat (15) @(posedge clk_50);
        hdr_sel = 1'b0;
        wait_done(0, 2);
        wait_done(1, 2);

        // Three bytes are not enough to start; the fourth starts a packet
        hdr_sel = 1'b0;
        queue_pkt(1'b0, 32'h0D0C0B0A);
        push_byte(8'h0A);
        push_byte(8'h0B);
        push_byte(8'h0C);
        de_snap[0] = de_total[0];
        de_snap[1] = de_total[1];
        repeat (100) @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("three_de_d%0d", i), de_total[i], de_snap[i]);
            check($sformatf("three_busy_d%0d", i), int'(bsy[i]), 0);
        end
        push_byte(8'h0D);
        check_latency("fourth");
        wait_done(0, 3);
        wait_done(1, 3);

        // Fill the FIFO with in_valid held high; two back-to-back packets
        for (int j = 0; j < 16; j++) fill[j] = 8'(8'hE0 + j);
        queue_pkt(1'b0, {fill[3], fill[2], fill[1], fill[0]});
        queue_pkt(1'b0, {fill[7], fill[6], fill[5], fill[4]});
        n = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk_50);
            if (!(rdy[0] && rdy[1])) break;
            in_data  = fill[n];
            in_valid = 1'b1;
            n++;
        end
        in_valid = 1'b0;
        check("fill_accepted", n, 8);
        check("fill_ready_d0", int'(rdy[0]), 0);
        check("fill_ready_d1", int'(rdy[1]), 0);
        check_b2b(0);
        check_b2b(1);
        wait_done(0, 5);
        wait_done(1, 5);

        // Reset during bit 4 of byte 2 aborts the packet for good
        send_pkt("pre_rst", 1'b0, 32'hDDCCBBAA);
        k = 0;
        do begin
            @(negedge clk_50);
            #1;
            k++;
        end while (!(bytes_in_pkt[0] == 2 && bit_idx[0] == 5) && k < 500);
        check("rst_trigger_found", int'(k < 500), 1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_rst_de_d%0d", i), int'(de[i]), 0);
            check($sformatf("mid_rst_sd_d%0d", i), int'(sd[i]), 0);
            check($sformatf("mid_rst_busy_d%0d", i), int'(bsy[i]), 0);
            check($sformatf("mid_rst_done_d%0d", i), int'(done[i]), 0);
            check($sformatf("mid_rst_ready_d%0d", i), int'(rdy[i]), 1);
            exp_q[i].delete();
        end
        repeat (2) @(negedge clk_50);
        #5;
        reset_n = 1'b1;
        de_snap[0] = de_total[0];
        de_snap[1] = de_total[1];
        done_snap[0] = done_cnt[0];
        done_snap[1] = done_cnt[1];
        repeat (100) @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("no_resume_de_d%0d", i), de_total[i], de_snap[i]);
            check($sformatf("no_resume_done_d%0d", i), done_cnt[i], done_snap[i]);
        end
        send_pkt("post_rst", 1'b1, 32'h04030201);
        wait_done(0, done_snap[0] + 1);
        wait_done(1, done_snap[1] + 1);

        repeat (5) @(posedge clk_50);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("sd_zero_when_idle_d%0d", i), sd_viol[i], 0);
            check($sformatf("queue_drained_d%0d", i), exp_q[i].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
